// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation engine.
package rsa_pkg;

  localparam int RSA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDUCE = 3'd1,
    ST_MUL_R  = 3'd2,
    ST_MUL_B  = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } rsa_exp_state_t;

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved MSB-first modular multiplier: p = a*b mod m, one multiplier bit per cycle.
// Needs a < m on entry; done is combinational in the last iteration so the caller can latch p that same edge.
module rsa_modmul #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             hold,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH+1:0] acc;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] m_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] red1;
  logic [WIDTH+1:0] red2;

  // acc < m always, so 2*acc + a stays below 3m and two subtractions suffice
  always_comb begin
    m_ext = {2'b00, m_r};
    sum   = {acc[WIDTH:0], 1'b0} + (b_r[WIDTH-1] ? {2'b00, a_r} : '0);
    red1  = (sum  >= m_ext) ? sum  - m_ext : sum;
    red2  = (red1 >= m_ext) ? red1 - m_ext : red1;
  end

  assign p    = red2[WIDTH-1:0];
  assign busy = (cnt != '0);
  assign done = busy && (cnt == CW'(1)) && !hold;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      acc <= '0;
      a_r <= '0;
      b_r <= '0;
      m_r <= '0;
      cnt <= '0;
    end else if (ena && !hold) begin
      if (start) begin
        acc <= '0;
        a_r <= a;
        b_r <= b;
        m_r <= m;
        cnt <= CW'(WIDTH);
      end else if (busy) begin
        acc <= red2;
        b_r <= {b_r[WIDTH-2:0], 1'b0};
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/rsa_exp_unit.sv
// Right-to-left square-and-multiply engine computing C = P^E mod M over one shared modmul.
//   state  | meaning
//   IDLE   | wait for en_rsa, capture P/E/M, R = 1 mod M
//   REDUCE | B = 1*P mod M
//   MUL_R  | R = R*B mod M (current exponent bit set)
//   MUL_B  | B = B*B mod M, then advance bit index (NEXT folded in)
//   NEXT   | never occupied; bit advance is decided in the last MUL_B cycle
//   DONE   | C = R, eoc held until rst_rsa=0
module rsa_exp_unit
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             en_rsa,
  input  logic             rst_rsa,
  input  logic [WIDTH-1:0] plain_text,
  input  logic [WIDTH-1:0] exp_e,
  input  logic [WIDTH-1:0] modulus_m,
  output logic [WIDTH-1:0] encrypted_text,
  output logic             eoc_rsa_unit
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  rsa_exp_state_t   state;
  logic [WIDTH-1:0] p_reg, e_reg, m_reg, r_reg, b_reg;
  logic [KW-1:0]    k, k_inc;
  logic             op_run, is_op, mm_start, mm_busy, mm_done, op_done;
  logic [WIDTH-1:0] mm_a, mm_b, mm_p;

  assign k_inc    = k + KW'(1);
  assign is_op    = (state == ST_REDUCE) || (state == ST_MUL_R) || (state == ST_MUL_B);
  assign mm_start = ena && rst_rsa && en_rsa && is_op && !op_run && (m_reg != '0);
  assign op_done  = op_run && mm_busy && mm_done;

  // REDUCE uses R (= 1 mod M at this point) as multiplicand so a < M holds even when P >= M
  always_comb begin
    mm_a = '0;
    mm_b = '0;
    case (state)
      ST_REDUCE: begin mm_a = r_reg; mm_b = p_reg; end
      ST_MUL_R:  begin mm_a = r_reg; mm_b = b_reg; end
      ST_MUL_B:  begin mm_a = b_reg; mm_b = b_reg; end
      default:   ;
    endcase
  end

  rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk   (clk),
    .rstb  (rstb),
    .ena   (ena),
    .hold  (!en_rsa),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .m     (m_reg),
    .busy  (mm_busy),
    .done  (mm_done),
    .p     (mm_p)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state          <= ST_IDLE;
      p_reg          <= '0;
      e_reg          <= '0;
      m_reg          <= '0;
      r_reg          <= '0;
      b_reg          <= '0;
      k              <= '0;
      op_run         <= 1'b0;
      encrypted_text <= '0;
      eoc_rsa_unit   <= 1'b0;
    end else if (ena) begin
      if (!rst_rsa) begin
        state          <= ST_IDLE;
        op_run         <= 1'b0;
        encrypted_text <= '0;
        eoc_rsa_unit   <= 1'b0;
      end else if (en_rsa) begin
        case (state)
          ST_IDLE: begin
            p_reg <= plain_text;
            e_reg <= exp_e;
            m_reg <= modulus_m;
            k     <= '0;
            r_reg <= (modulus_m == WIDTH'(1)) ? '0 : WIDTH'(1);
            state <= ST_REDUCE;
          end
          ST_REDUCE: begin
            if (m_reg == '0) begin
              encrypted_text <= '0;
              eoc_rsa_unit   <= 1'b1;
              state          <= ST_DONE;
            end else if (!op_run) begin
              op_run <= 1'b1;
            end else if (op_done) begin
              b_reg  <= mm_p;
              op_run <= 1'b0;
              state  <= e_reg[0] ? ST_MUL_R : ST_MUL_B;
            end
          end
          ST_MUL_R: begin
            if (!op_run) begin
              op_run <= 1'b1;
            end else if (op_done) begin
              r_reg  <= mm_p;
              op_run <= 1'b0;
              state  <= ST_MUL_B;
            end
          end
          ST_MUL_B: begin
            if (!op_run) begin
              op_run <= 1'b1;
            end else if (op_done) begin
              b_reg  <= mm_p;
              op_run <= 1'b0;
              if (k == KW'(WIDTH - 1)) begin
                encrypted_text <= r_reg;
                eoc_rsa_unit   <= 1'b1;
                state          <= ST_DONE;
              end else begin
                k     <= k_inc;
                state <= e_reg[k_inc] ? ST_MUL_R : ST_MUL_B;
              end
            end
          end
          ST_DONE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
